vga_timing_gen: RTL

//  Parametrised VGA/raster timing generator, successor to the fixed 640x480 core.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 32 +++
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default raster timing sets and helpers shared by the VGA timing generator.
package vga_timing_pkg;

    // One axis of a raster: visible span followed by front porch, sync, back porch.
    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs.
    localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam bit           VGA640_HS_POL = 1'b0;
    localparam bit           VGA640_VS_POL = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
    localparam axis_timing_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam axis_timing_t SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};
    localparam bit           SVGA800_HS_POL = 1'b1;
    localparam bit           SVGA800_VS_POL = 1'b1;

    // Full period of one axis in ticks (horizontal) or lines (vertical).
    function automatic int total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; advances on tick.
module vga_axis_counter #(
    parameter int TOTAL   = 800,
    parameter int CW      = 12,
    parameter int RST_VAL = TOTAL - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] RST  = CW'(RST_VAL);

    logic [CW-1:0] r_cnt;

    // Count up on each tick, returning to zero after the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST;
        end else if (tick) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign cnt  = r_cnt;
    // High while sitting on the last position: the next tick wraps to zero.
    assign wrap = (r_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock enable, frame/line
// strobes and a lead (prefetch) position running PREFETCH ticks ahead.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H.active,
    parameter int H_FP     = VGA640_H.fp,
    parameter int H_SYNC   = VGA640_H.sync,
    parameter int H_BP     = VGA640_H.bp,
    parameter int V_ACTIVE = VGA640_V.active,
    parameter int V_FP     = VGA640_V.fp,
    parameter int V_SYNC   = VGA640_V.sync,
    parameter int V_BP     = VGA640_V.bp,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL,
    parameter int PREFETCH = 0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          req_active,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Lead counter starts so that the first tick lands it PREFETCH ahead of (0,0).
    localparam int RH_RST = (PREFETCH == 0) ? H_TOTAL - 1 : PREFETCH - 1;
    localparam int RV_RST = (PREFETCH == 0) ? V_TOTAL - 1 : 0;

    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] w_h;
    logic [CW-1:0] w_v;
    logic [CW-1:0] w_rh;
    logic [CW-1:0] w_rv;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_rh_wrap;
    logic          w_rv_wrap;
    logic          w_v_tick;
    logic          w_rv_tick;

    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic [CW-1:0] w_rh_nxt;
    logic [CW-1:0] w_rv_nxt;

    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_line_start;
    logic r_frame_start;
    logic r_req_active;

    assign w_v_tick  = en & w_h_wrap;
    assign w_rv_tick = en & w_rh_wrap;

    vga_axis_counter #(
        .TOTAL   (H_TOTAL),
        .CW      (CW),
        .RST_VAL (H_TOTAL - 1)
    ) u_h_main (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (en),
        .cnt   (w_h),
        .wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .TOTAL   (V_TOTAL),
        .CW      (CW),
        .RST_VAL (V_TOTAL - 1)
    ) u_v_main (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_v_tick),
        .cnt   (w_v),
        .wrap  (w_v_wrap)
    );

    vga_axis_counter #(
        .TOTAL   (H_TOTAL),
        .CW      (CW),
        .RST_VAL (RH_RST)
    ) u_h_lead (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (en),
        .cnt   (w_rh),
        .wrap  (w_rh_wrap)
    );

    vga_axis_counter #(
        .TOTAL   (V_TOTAL),
        .CW      (CW),
        .RST_VAL (RV_RST)
    ) u_v_lead (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_rv_tick),
        .cnt   (w_rv),
        .wrap  (w_rv_wrap)
    );

    // Position each counter pair will hold after the coming en tick; decoding
    // this instead of the current count keeps the flags aligned with the counters.
    always_comb begin
        w_h_nxt  = w_h_wrap ? '0 : w_h + CW'(1);
        w_v_nxt  = w_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : w_v + CW'(1);
        end
        w_rh_nxt = w_rh_wrap ? '0 : w_rh + CW'(1);
        w_rv_nxt = w_rv;
        if (w_rh_wrap) begin
            w_rv_nxt = w_rv_wrap ? '0 : w_rv + CW'(1);
        end
    end

    // Level outputs: decode the upcoming position, hold while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_video_on   <= 1'b0;
            r_hsync      <= ~HS_POL;
            r_vsync      <= ~VS_POL;
            r_req_active <= 1'b0;
        end else if (en) begin
            r_video_on   <= (w_h_nxt < H_ACT_END) && (w_v_nxt < V_ACT_END);
            r_hsync      <= ((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END)) ? HS_POL : ~HS_POL;
            r_vsync      <= ((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END)) ? VS_POL : ~VS_POL;
            r_req_active <= (w_rh_nxt < H_ACT_END) && (w_rv_nxt < V_ACT_END);
        end
    end

    // Strobes: one clk wide, raised only on the tick that lands on h=0 / (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= en & w_h_wrap;
            r_frame_start <= en & w_h_wrap & w_v_wrap;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign req_active  = r_req_active;
    assign pixel_x     = w_h;
    assign pixel_y     = w_v;
    assign req_x       = w_rh;
    assign req_y       = w_rv;

endmodule
